// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, canonical NOP encoding and fetch-stage states.
package cpu_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones until reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: PC and IF/ID registers, stall/redirect handling, bubble request,
// saturating stall/flush counters and a sticky stuck-stall watchdog.
module fetch_stage_ctrl #(
  parameter int unsigned     XLEN      = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     MAX_STALL = 8,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [XLEN-1:0]  branch_target_i,
  output logic [XLEN-1:0]  imem_addr_o,
  input  logic [31:0]      imem_rdata_i,
  output logic [XLEN-1:0]  ifid_pc_o,
  output logic [31:0]      ifid_instr_o,
  output logic             ifid_valid_o,
  output logic             idex_bubble_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             stall_timeout_o
);

  import cpu_pkg::*;

  localparam int unsigned RL_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] ifid_pc_q;
  logic [31:0]     ifid_instr_q;
  logic            ifid_valid_q;
  logic [RL_W-1:0] run_len_q;
  logic            timeout_q;
  logic            stall_inc;
  logic            flush_inc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state: a redirect outranks a stall, anything else advances
  always_comb begin
    state_d = RUN;
    if (branch_taken_i)  state_d = FLUSH;
    else if (stall_i)    state_d = HOLD;
  end

  // Per-edge controls; bubble is suppressed while reset is held
  always_comb begin
    idex_bubble_o = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    if (!rst) begin
      idex_bubble_o = stall_i | branch_taken_i;
      flush_inc     = branch_taken_i;
      stall_inc     = stall_i & ~branch_taken_i;
    end
  end

  // PC, IF/ID and watchdog; the IF/ID PC field is kept on a kill
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      run_len_q    <= '0;
      timeout_q    <= 1'b0;
    end else if (branch_taken_i) begin
      pc_q         <= branch_target_i;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      run_len_q    <= '0;
    end else if (stall_i) begin
      if (run_len_q != RL_W'(MAX_STALL)) run_len_q <= run_len_q + RL_W'(1);
      if (run_len_q == RL_W'(MAX_STALL - 1)) timeout_q <= 1'b1;
    end else begin
      pc_q         <= pc_q + XLEN'(4);
      ifid_pc_q    <= pc_q;
      ifid_instr_q <= imem_rdata_i;
      ifid_valid_q <= 1'b1;
      run_len_q    <= '0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt_o)
  );

  assign imem_addr_o     = pc_q;
  assign ifid_pc_o       = ifid_pc_q;
  assign ifid_instr_o    = ifid_instr_q;
  assign ifid_valid_o    = ifid_valid_q;
  assign state_o         = 2'(state_q);
  assign stall_timeout_o = timeout_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl: driver queues hand-computed expectations,
// a monitor pops one per clock edge and compares.
module tb_fetch_stage_ctrl;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_instr_o;
  logic        ifid_valid_o;
  logic        idex_bubble_o;
  logic [1:0]  state_o;
  logic [1:0]  stall_cnt_o;
  logic [1:0]  flush_cnt_o;
  logic        stall_timeout_o;

  fetch_stage_ctrl #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .MAX_STALL (8),
    .CNT_W     (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .imem_addr_o     (imem_addr_o),
    .imem_rdata_i    (imem_rdata_i),
    .ifid_pc_o       (ifid_pc_o),
    .ifid_instr_o    (ifid_instr_o),
    .ifid_valid_o    (ifid_valid_o),
    .idex_bubble_o   (idex_bubble_o),
    .state_o         (state_o),
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o),
    .stall_timeout_o (stall_timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word at addr is 0xA000_0000 | (addr >> 2)
  always_comb imem_rdata_i = 32'hA000_0000 | (imem_addr_o >> 2);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [31:0] instr;
    logic        v;
    logic [1:0]  st;
    logic [1:0]  sc;
    logic [1:0]  fc;
    logic        to;
    logic        bub;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%h expected=%h", name, vec_no, act, want);
    end
  endtask

  // Apply inputs for the next edge and queue the post-edge expectation
  task automatic vec(input logic r, input logic s, input logic b, input logic [31:0] tgt,
                     input logic [31:0] pc, input logic [31:0] ipc, input logic [31:0] instr,
                     input logic v, input logic [1:0] st, input logic [1:0] sc,
                     input logic [1:0] fc, input logic to, input logic bub);
    exp_t e;
    @(negedge clk);
    rst = r; stall_i = s; branch_taken_i = b; branch_target_i = tgt;
    e.pc = pc; e.ipc = ipc; e.instr = instr; e.v = v; e.st = st;
    e.sc = sc; e.fc = fc; e.to = to; e.bub = bub;
    exp_q.push_back(e);
  endtask

  // Monitor: bubble sampled before the edge, registers just after it
  initial begin
    exp_t  e;
    logic  bub;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        bub = idex_bubble_o;
        #1;
        chk("bubble",    32'(bub),             32'(e.bub));
        chk("imem_addr", imem_addr_o,          e.pc);
        chk("ifid_pc",   ifid_pc_o,            e.ipc);
        chk("ifid_instr", ifid_instr_o,        e.instr);
        chk("ifid_valid", 32'(ifid_valid_o),   32'(e.v));
        chk("state",     32'(state_o),         32'(e.st));
        chk("stall_cnt", 32'(stall_cnt_o),     32'(e.sc));
        chk("flush_cnt", 32'(flush_cnt_o),     32'(e.fc));
        chk("timeout",   32'(stall_timeout_o), 32'(e.to));
        vec_no++;
      end
    end
  end

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    rst = 1'b1; stall_i = 1'b0; branch_taken_i = 1'b0; branch_target_i = '0;
    //    rst s  b  target        pc            ifid_pc       instr         v  st  sc  fc  to bub
    vec(1, 0, 0, 32'h0,         32'h0,        32'h0,        NOP,          0, 0,  0,  0,  0, 0);
    vec(1, 1, 0, 32'h0,         32'h0,        32'h0,        NOP,          0, 0,  0,  0,  0, 0);
    vec(0, 0, 0, 32'h0,         32'h4,        32'h0,        32'hA0000000, 1, 0,  0,  0,  0, 0);
    vec(0, 0, 0, 32'h0,         32'h8,        32'h4,        32'hA0000001, 1, 0,  0,  0,  0, 0);
    vec(0, 1, 0, 32'h0,         32'h8,        32'h4,        32'hA0000001, 1, 1,  1,  0,  0, 1);
    vec(0, 1, 0, 32'h0,         32'h8,        32'h4,        32'hA0000001, 1, 1,  2,  0,  0, 1);
    vec(0, 0, 0, 32'h0,         32'hC,        32'h8,        32'hA0000002, 1, 0,  2,  0,  0, 0);
    vec(0, 0, 0, 32'h0,         32'h10,       32'hC,        32'hA0000003, 1, 0,  2,  0,  0, 0);
    vec(0, 0, 1, 32'h100,       32'h100,      32'hC,        NOP,          0, 2,  2,  1,  0, 1);
    vec(0, 0, 0, 32'h0,         32'h104,      32'h100,      32'hA0000040, 1, 0,  2,  1,  0, 0);
    vec(0, 1, 1, 32'h200,       32'h200,      32'h100,      NOP,          0, 2,  2,  2,  0, 1);
    vec(0, 0, 0, 32'h0,         32'h204,      32'h200,      32'hA0000080, 1, 0,  2,  2,  0, 0);
    // eight consecutive stalls: counter saturates at 3, watchdog fires on the 8th
    for (int i = 1; i <= 8; i++)
      vec(0, 1, 0, 32'h0,       32'h204,      32'h200,      32'hA0000080, 1, 1,  3,  2,  (i == 8), 1);
    vec(0, 0, 0, 32'h0,         32'h208,      32'h204,      32'hA0000081, 1, 0,  3,  2,  1, 0);
    vec(0, 0, 1, 32'h40,        32'h40,       32'h204,      NOP,          0, 2,  3,  3,  1, 1);
    vec(0, 1, 0, 32'h0,         32'h40,       32'h204,      NOP,          0, 1,  3,  3,  1, 1);
    // reset mid-stall with a branch also present
    vec(1, 1, 1, 32'h80,        32'h0,        32'h0,        NOP,          0, 0,  0,  0,  0, 0);
    vec(0, 0, 1, 32'hFFFFFFF8,  32'hFFFFFFF8, 32'h0,        NOP,          0, 2,  0,  1,  0, 1);
    vec(0, 0, 0, 32'h0,         32'hFFFFFFFC, 32'hFFFFFFF8, 32'hBFFFFFFE, 1, 0,  0,  1,  0, 0);
    vec(0, 0, 0, 32'h0,         32'h0,        32'hFFFFFFFC, 32'hBFFFFFFF, 1, 0,  0,  1,  0, 0);
    vec(0, 0, 1, 32'h4,         32'h4,        32'hFFFFFFFC, NOP,          0, 2,  0,  2,  0, 1);
    vec(0, 0, 1, 32'h8,         32'h8,        32'hFFFFFFFC, NOP,          0, 2,  0,  3,  0, 1);
    vec(0, 0, 1, 32'hC,         32'hC,        32'hFFFFFFFC, NOP,          0, 2,  0,  3,  0, 1);
    vec(0, 0, 0, 32'h0,         32'h10,       32'hC,        32'hA0000003, 1, 0,  0,  3,  0, 0);
    @(negedge clk);
    stall_i = 1'b0; branch_taken_i = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
